// File: rtl/rvj1_ifu_q.sv
// rvj1 instruction fetch unit. Issues fetch requests with several in flight,
// queues responses tagged with their PC and bus error flag, and feeds the
// decoder from the head. Jumps flush the queue and discard stale responses;
// a misaligned target halts fetch and raises a one-cycle exception pulse.
module rvj1_ifu_q #(
  parameter logic [31:0] BOOT_ADDR       = 32'h8000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [31:0] instr_req_addr_o,
  output logic [31:0] instr_req_data_o,
  output logic [3:0]  instr_req_strobe_o,
  output logic        instr_req_write_o,
  output logic        instr_req_valid_o,
  input  logic        instr_req_ready_i,
  input  logic [31:0] instr_rsp_data_i,
  input  logic        instr_rsp_error_i,
  input  logic        instr_rsp_valid_i,
  output logic        instr_rsp_ready_o,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o,
  output logic        dec_error_o,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  input  logic        jmp_addr_valid_i,
  input  logic [31:0] jmp_addr_i,
  output logic        ctrl_insn_misalign_exception_o,
  output logic [31:0] ctrl_fault_addr_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);

  typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } q_entry_t;

  state_e        state_q, state_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   redir_addr_q, redir_addr_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   fault_q;
  logic          req_valid_q, req_valid_d;
  logic          redir_q, redir_d;
  logic          rsp_ready_q, exc_q;
  logic [OW-1:0] out_q, out_d, discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   occ_d;
  logic [PW-1:0] wr_q, rd_q;
  q_entry_t      q_mem [QUEUE_DEPTH];
  q_entry_t      head;
  logic          req_fire, rsp_fire, jump, misalign, push, pop;

  assign req_fire = req_valid_q & instr_req_ready_i;
  assign rsp_fire = instr_rsp_valid_i & rsp_ready_q;
  assign jump     = jmp_addr_valid_i;
  assign misalign = jump & (jmp_addr_i[1:0] != 2'b00);
  // Responses owed to pre-jump requests, or arriving on the jump edge, never enter the queue.
  assign push     = rsp_fire & (discard_q == '0) & ~jump;
  assign pop      = (count_q != '0) & dec_ready_i & ~jump;

  // Next state: any jump picks the state, misaligned targets park the fetcher.
  always_comb begin
    state_d = state_q;
    if (jump) state_d = misalign ? S_HALT : S_FETCH;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Counters, issue decision and fetch/redirect address bookkeeping.
  always_comb begin
    out_d   = out_q + OW'(req_fire) - OW'(rsp_fire);
    count_d = jump ? '0 : count_q + CW'(push) - CW'(pop);
    occ_d   = (CW+1)'(out_d) + (CW+1)'(count_d);

    // On a jump every response still owed is stale; the pending unfired
    // request (if any) is added when it finally fires.
    discard_d = discard_q;
    if (jump) begin
      discard_d = out_d;
    end else begin
      if (rsp_fire && discard_q != '0) discard_d = discard_d - OW'(1);
      if (req_fire && redir_q)         discard_d = discard_d + OW'(1);
    end

    // A pending request stays up until it fires; otherwise issue whenever
    // both the outstanding limit and the queue reservation allow it.
    req_valid_d = (req_valid_q & ~instr_req_ready_i) |
                  ((state_d == S_FETCH) && (out_d < OW'(MAX_OUTSTANDING)) &&
                   (occ_d < (CW+1)'(QUEUE_DEPTH)));

    req_addr_d   = req_addr_q;
    redir_d      = redir_q;
    redir_addr_d = redir_addr_q;
    if (jump) begin
      if (req_valid_q && !req_fire) begin
        redir_d      = 1'b1;
        redir_addr_d = jmp_addr_i;
      end else begin
        req_addr_d = jmp_addr_i;
        redir_d    = 1'b0;
      end
    end else if (req_fire) begin
      if (redir_q) begin
        req_addr_d = redir_addr_q;
        redir_d    = 1'b0;
      end else begin
        req_addr_d = req_addr_q + 32'd4;
      end
    end

    rsp_pc_d = rsp_pc_q;
    if (jump)      rsp_pc_d = jmp_addr_i;
    else if (push) rsp_pc_d = rsp_pc_q + 32'd4;
  end

  // Fetch-side registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_addr_q   <= BOOT_ADDR;
      req_valid_q  <= 1'b0;
      redir_q      <= 1'b0;
      redir_addr_q <= '0;
      rsp_pc_q     <= BOOT_ADDR;
      rsp_ready_q  <= 1'b0;
      out_q        <= '0;
      discard_q    <= '0;
      exc_q        <= 1'b0;
      fault_q      <= '0;
    end else begin
      req_addr_q   <= req_addr_d;
      req_valid_q  <= req_valid_d;
      redir_q      <= redir_d;
      redir_addr_q <= redir_addr_d;
      rsp_pc_q     <= rsp_pc_d;
      rsp_ready_q  <= 1'b1;
      out_q        <= out_d;
      discard_q    <= discard_d;
      exc_q        <= misalign;
      if (misalign) fault_q <= jmp_addr_i;
    end
  end

  // Instruction queue: circular buffer, pointers rewind on flush.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q_mem[i] <= '0;
    end else begin
      count_q <= count_d;
      if (jump) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
      end
      if (push) q_mem[wr_q] <= '{pc: rsp_pc_q, instr: instr_rsp_data_i, err: instr_rsp_error_i};
    end
  end

  assign head = q_mem[rd_q];

  assign instr_req_addr_o               = req_addr_q;
  assign instr_req_data_o               = '0;
  assign instr_req_strobe_o             = '1;
  assign instr_req_write_o              = 1'b0;
  assign instr_req_valid_o              = req_valid_q;
  assign instr_rsp_ready_o              = rsp_ready_q;
  assign dec_instr_o                    = head.instr;
  assign dec_pc_o                       = head.pc;
  assign dec_error_o                    = head.err;
  assign dec_valid_o                    = (count_q != '0);
  assign ctrl_insn_misalign_exception_o = exc_q;
  assign ctrl_fault_addr_o              = fault_q;

endmodule

// File: tb/tb_rvj1_ifu_q.sv
// Bench for rvj1_ifu_q: a memory model with configurable latency, a decoder
// with configurable readiness, and a scoreboard of expected queue entries.
module tb_rvj1_ifu_q;

  localparam logic [31:0] BOOT = 32'h8000_0000;
  localparam int          MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic [31:0] instr_req_addr_o, instr_req_data_o;
  logic [3:0]  instr_req_strobe_o;
  logic        instr_req_write_o, instr_req_valid_o;
  logic        instr_req_ready_i = 1'b0;
  logic [31:0] instr_rsp_data_i = '0;
  logic        instr_rsp_error_i = 1'b0, instr_rsp_valid_i = 1'b0;
  logic        instr_rsp_ready_o;
  logic [31:0] dec_instr_o, dec_pc_o;
  logic        dec_error_o, dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic        jmp_addr_valid_i = 1'b0;
  logic [31:0] jmp_addr_i = '0;
  logic        ctrl_insn_misalign_exception_o;
  logic [31:0] ctrl_fault_addr_o;

  rvj1_ifu_q #(.BOOT_ADDR(BOOT), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .instr_req_addr_o(instr_req_addr_o), .instr_req_data_o(instr_req_data_o),
    .instr_req_strobe_o(instr_req_strobe_o), .instr_req_write_o(instr_req_write_o),
    .instr_req_valid_o(instr_req_valid_o), .instr_req_ready_i(instr_req_ready_i),
    .instr_rsp_data_i(instr_rsp_data_i), .instr_rsp_error_i(instr_rsp_error_i),
    .instr_rsp_valid_i(instr_rsp_valid_i), .instr_rsp_ready_o(instr_rsp_ready_o),
    .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o), .dec_error_o(dec_error_o),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .jmp_addr_valid_i(jmp_addr_valid_i), .jmp_addr_i(jmp_addr_i),
    .ctrl_insn_misalign_exception_o(ctrl_insn_misalign_exception_o),
    .ctrl_fault_addr_o(ctrl_fault_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int tag; int due; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } exp_t;

  int checks = 0, errors = 0;

  // knobs
  logic        dec_rdy = 1'b1, rnd_on = 1'b0, jmp_pend = 1'b0;
  logic [31:0] jmp_tgt = '0, xor_key = '0, err_addr = 32'h1;
  int          delay = 0;

  // model state
  mem_t        mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] exp_addr, first_pc;
  logic        stale_next, halted, first_pend;
  int          epoch, out, max_out, last_due, cyc, pops, fires, err_pops;

  task automatic model_reset();
    mem_q.delete(); exp_q.delete();
    exp_addr = BOOT; first_pc = '0; first_pend = 1'b1;
    stale_next = 1'b0; halted = 1'b0;
    epoch = 0; out = 0; max_out = 0; last_due = 0; cyc = 0;
    pops = 0; fires = 0; err_pops = 0;
  endtask

  // One clock: drive inputs at the falling edge, predict what the next rising
  // edge consumes, then return 1 ns after that rising edge.
  task automatic cycle();
    logic jump, rfire, qfire, pop, stale;
    mem_t m, nm;
    exp_t e;
    int   d;
    @(negedge clk_i);
    checks++;
    if (dec_valid_o !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL dec_valid: got %b expected %b at cycle %0d", dec_valid_o, exp_q.size() != 0, cyc);
    end
    jump = jmp_pend; jmp_pend = 1'b0;
    jmp_addr_valid_i  = jump;
    jmp_addr_i        = jump ? jmp_tgt : 32'h0;
    dec_ready_i       = rnd_on ? 1'($urandom_range(0, 1)) : dec_rdy;
    instr_req_ready_i = rnd_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    qfire = (instr_rsp_ready_o === 1'b1) && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    m = '{addr: '0, tag: 0, due: 0};
    if (qfire) m = mem_q.pop_front();
    instr_rsp_valid_i = qfire;
    instr_rsp_data_i  = qfire ? (m.addr ^ xor_key) : 32'h0;
    instr_rsp_error_i = qfire && (m.addr == err_addr);
    rfire = (instr_req_valid_o === 1'b1) && instr_req_ready_i;
    pop   = (dec_valid_o === 1'b1) && dec_ready_i && !jump;

    if (pop && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({dec_pc_o, dec_instr_o, dec_error_o} !== {e.pc, e.instr, e.err}) begin
        errors++;
        $display("FAIL dec_entry: got pc=%h instr=%h err=%b expected pc=%h instr=%h err=%b",
                 dec_pc_o, dec_instr_o, dec_error_o, e.pc, e.instr, e.err);
      end
      pops++;
      if (dec_error_o === 1'b1) err_pops++;
      if (first_pend) begin first_pc = dec_pc_o; first_pend = 1'b0; end
    end

    if (qfire) begin
      out--;
      if (m.tag == epoch && !jump) begin
        e.pc = m.addr; e.instr = m.addr ^ xor_key; e.err = (m.addr == err_addr);
        exp_q.push_back(e);
      end
    end

    if (rfire) begin
      stale = jump || stale_next;
      stale_next = 1'b0;
      if (!stale) begin
        checks++;
        if (instr_req_addr_o !== exp_addr || halted) begin
          errors++;
          $display("FAIL req_addr: got %h expected %h (halted=%b)", instr_req_addr_o, exp_addr, halted);
        end
        exp_addr += 32'd4;
        fires++;
      end
      d = rnd_on ? int'($urandom_range(0, 4)) : delay;
      nm.addr = instr_req_addr_o; nm.tag = stale ? -1 : epoch;
      nm.due = (last_due > cyc + 1 + d) ? last_due : cyc + 1 + d;
      last_due = nm.due;
      mem_q.push_back(nm);
      out++;
      if (out > max_out) max_out = out;
    end

    if (jump) begin
      epoch++;
      exp_q.delete();
      stale_next = (instr_req_valid_o === 1'b1) && !rfire;
      exp_addr   = jmp_tgt;
      halted     = (jmp_tgt[1:0] != 2'b00);
      first_pend = 1'b1;
    end
    cyc++;
    @(posedge clk_i); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_jump(input logic [31:0] tgt);
    jmp_tgt = tgt; jmp_pend = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    #1 rstn_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (instr_req_addr_o !== BOOT) begin errors++; $display("FAIL reset_addr: got %h expected %h", instr_req_addr_o, BOOT); end
    checks++;
    if ({instr_req_valid_o, instr_rsp_ready_o, dec_valid_o, dec_error_o, ctrl_insn_misalign_exception_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000",
        {instr_req_valid_o, instr_rsp_ready_o, dec_valid_o, dec_error_o, ctrl_insn_misalign_exception_o});
    end
    checks++;
    if ({dec_instr_o, dec_pc_o, ctrl_fault_addr_o} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h expected zeros", dec_instr_o, dec_pc_o, ctrl_fault_addr_o);
    end
    checks++;
    if ({instr_req_data_o, instr_req_strobe_o, instr_req_write_o} !== {32'h0, 4'hf, 1'b0}) begin
      errors++; $display("FAIL tied_outputs: got %h %h %b expected 0 f 0", instr_req_data_o, instr_req_strobe_o, instr_req_write_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if ({instr_rsp_ready_o, instr_req_valid_o, dec_valid_o} !== 3'b110 || instr_req_addr_o !== BOOT) begin
      errors++; $display("FAIL post_reset: got rdy/vld/dec=%b addr=%h expected 110 %h",
        {instr_rsp_ready_o, instr_req_valid_o, dec_valid_o}, instr_req_addr_o, BOOT);
    end
  endtask

  task automatic test_stream();
    int p0;
    dec_rdy = 1'b1; delay = 0; xor_key = '0;
    p0 = pops;
    run(40);
    checks++;
    if (pops - p0 < 20) begin errors++; $display("FAIL stream_progress: got %0d pops expected >= 20", pops - p0); end
    checks++;
    if (first_pc !== BOOT) begin errors++; $display("FAIL stream_first_pc: got %h expected %h", first_pc, BOOT); end
  endtask

  task automatic test_queue_full();
    int f0, p0;
    dec_rdy = 1'b0; delay = 0; xor_key = 32'h0f0f_0000;
    do_jump(32'h8000_1000);
    f0 = fires;
    run(20);
    checks++;
    if (fires - f0 != 4) begin errors++; $display("FAIL full_fires: got %0d expected 4", fires - f0); end
    checks++;
    if (instr_req_valid_o !== 1'b0 || dec_pc_o !== 32'h8000_1000) begin
      errors++; $display("FAIL full_state: got vld=%b head=%h expected 0 80001000", instr_req_valid_o, dec_pc_o);
    end
    dec_rdy = 1'b1;
    p0 = pops;
    run(20);
    checks++;
    if (pops - p0 < 4 || fires - f0 <= 4) begin
      errors++; $display("FAIL full_resume: got pops=%0d fires=%0d expected >=4 and >4", pops - p0, fires - f0);
    end
  endtask

  task automatic test_outstanding();
    int p0;
    dec_rdy = 1'b1; delay = 5; xor_key = 32'h1234_5678;
    do_jump(32'h8000_2000);
    max_out = 0; p0 = pops;
    run(60);
    checks++;
    if (max_out != MAXO) begin errors++; $display("FAIL max_outstanding: got %0d expected %0d", max_out, MAXO); end
    checks++;
    if (pops - p0 < 5) begin errors++; $display("FAIL outstanding_progress: got %0d pops expected >= 5", pops - p0); end
  endtask

  task automatic test_jump_flush();
    int n = 0, p0;
    dec_rdy = 1'b0; delay = 3; xor_key = 32'h0000_ffff;
    do_jump(32'h8000_3000);
    while (!(exp_q.size() >= 2 && out == 2) && n < 100) begin cycle(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL flush_setup: got timeout expected 2 queued and 2 in flight"); end
    do_jump(32'h8000_0100);
    checks++;
    if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", dec_valid_o); end
    dec_rdy = 1'b1; p0 = pops;
    run(25);
    checks++;
    if (first_pc !== 32'h8000_0100 || pops == p0) begin
      errors++; $display("FAIL flush_first_pc: got %h (pops %0d) expected 80000100", first_pc, pops - p0);
    end
  endtask

  task automatic test_misalign();
    int f0;
    dec_rdy = 1'b1; delay = 1; xor_key = 32'habcd_0000;
    run(10);
    do_jump(32'h8000_0102);
    checks++;
    if (ctrl_insn_misalign_exception_o !== 1'b1 || ctrl_fault_addr_o !== 32'h8000_0102) begin
      errors++; $display("FAIL misalign_pulse: got exc=%b fault=%h expected 1 80000102",
        ctrl_insn_misalign_exception_o, ctrl_fault_addr_o);
    end
    f0 = fires;
    cycle();
    checks++;
    if (ctrl_insn_misalign_exception_o !== 1'b0 || ctrl_fault_addr_o !== 32'h8000_0102) begin
      errors++; $display("FAIL misalign_hold: got exc=%b fault=%h expected 0 80000102",
        ctrl_insn_misalign_exception_o, ctrl_fault_addr_o);
    end
    run(15);
    checks++;
    if (instr_req_valid_o !== 1'b0 || fires != f0) begin
      errors++; $display("FAIL halt: got vld=%b fires=%0d expected 0 0", instr_req_valid_o, fires - f0);
    end
    do_jump(32'h8000_0200);
    checks++;
    if (ctrl_insn_misalign_exception_o !== 1'b0) begin errors++; $display("FAIL aligned_no_exc: got 1 expected 0"); end
    run(20);
    checks++;
    if (first_pc !== 32'h8000_0200) begin errors++; $display("FAIL resume_pc: got %h expected 80000200", first_pc); end
  endtask

  task automatic test_bus_error();
    int e0, p0;
    dec_rdy = 1'b1; delay = 0; xor_key = 32'h5a5a_5a5a; err_addr = 32'h8000_0008;
    do_jump(32'h8000_0000);
    e0 = err_pops; p0 = pops;
    run(20);
    checks++;
    if (err_pops - e0 != 1 || pops - p0 < 6) begin
      errors++; $display("FAIL bus_error: got err_pops=%0d pops=%0d expected 1 and >=6", err_pops - e0, pops - p0);
    end
    err_addr = 32'h1;
  endtask

  task automatic test_random();
    int p0;
    rnd_on = 1'b1; xor_key = 32'hc3c3_3c3c;
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        jmp_tgt = 32'h8000_4000 + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 7) == 0) jmp_tgt[0] = 1'b1;
        jmp_pend = 1'b1;
      end
      cycle();
    end
    rnd_on = 1'b0; dec_rdy = 1'b1; delay = 0;
    do_jump(32'h8000_5000);
    run(20);
    checks++;
    if (pops - p0 < 20) begin errors++; $display("FAIL random_progress: got %0d pops expected >= 20", pops - p0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_queue_full();
    test_outstanding();
    test_jump_flush();
    test_misalign();
    test_bus_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
